// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the 5-stage MIPS core: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use / RAW stall, branch/jump flush and forwarding select. Optional macro: CTRL_FORWARD_EN.
module pipe_ctrl_unit #(
  parameter int ALUCTR_W = 3,
  parameter int RADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic [RADDR_W-1:0]  rs,
  input  logic [RADDR_W-1:0]  rt,
  input  logic [RADDR_W-1:0]  rd,
  input  logic                zero,
  output logic                stall_o,
  output logic                flush_o,
  output logic                jump_o,
  output logic                br_take_o,
  output logic                ExtOp_o,
  output logic                illegal_o,
  output logic                ex_ALUsrc,
  output logic [ALUCTR_W-1:0] ex_ALUctr,
  output logic [1:0]          fwdA,
  output logic [1:0]          fwdB,
  output logic                mem_MemWr,
  output logic                wb_RegWr,
  output logic                wb_MemtoReg,
  output logic [RADDR_W-1:0]  wb_waddr
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(0);
  localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(1);
  localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(2);
  localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(3);
  localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(4);

  logic                d_regwr, d_regdst, d_alusrc, d_memtoreg, d_memwr;
  logic                d_branch, d_brne, d_jump, d_extop, d_illegal, d_rtread;
  logic [ALUCTR_W-1:0] d_aluctr;
  logic [RADDR_W-1:0]  d_waddr;

  always_comb begin
    d_regwr    = 1'b0;
    d_regdst   = 1'b0;
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_memwr    = 1'b0;
    d_branch   = 1'b0;
    d_brne     = 1'b0;
    d_jump     = 1'b0;
    d_extop    = 1'b0;
    d_illegal  = 1'b0;
    d_rtread   = 1'b0;
    d_aluctr   = ALU_ADD;
    case (op)
      OP_R: begin
        d_regwr  = 1'b1;
        d_regdst = 1'b1;
        d_rtread = 1'b1;
        case (func)
          FN_ADD:  d_aluctr = ALU_ADD;
          FN_SUB:  d_aluctr = ALU_SUB;
          FN_AND:  d_aluctr = ALU_AND;
          FN_OR:   d_aluctr = ALU_OR;
          FN_SLT:  d_aluctr = ALU_SLT;
          default: begin
            d_illegal = 1'b1;
            d_regwr   = 1'b0;
            d_regdst  = 1'b0;
            d_rtread  = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        d_alusrc   = 1'b1;
        d_memtoreg = 1'b1;
        d_regwr    = 1'b1;
        d_extop    = 1'b1;
      end
      OP_SW: begin
        d_alusrc = 1'b1;
        d_memwr  = 1'b1;
        d_extop  = 1'b1;
        d_rtread = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d_branch = 1'b1;
        d_brne   = (op == OP_BNE);
        d_extop  = 1'b1;
        d_rtread = 1'b1;
        d_aluctr = ALU_SUB;
      end
      OP_J:    d_jump = 1'b1;
      OP_ADDI: begin
        d_alusrc = 1'b1;
        d_regwr  = 1'b1;
        d_extop  = 1'b1;
      end
      OP_ORI: begin
        d_alusrc = 1'b1;
        d_regwr  = 1'b1;
        d_aluctr = ALU_OR;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_waddr = d_regdst ? rd : rt;

  logic               ex_regwr, ex_memtoreg, ex_memwr, ex_branch, ex_brne;
  logic [RADDR_W-1:0] ex_waddr;
  logic               mem_regwr, mem_memtoreg;
  logic [RADDR_W-1:0] mem_waddr;
  logic               br_take, hazard, ex_hit, mem_hit;

  assign ex_hit  = (ex_waddr != '0) && ((ex_waddr == rs) || (d_rtread && ex_waddr == rt));
  assign mem_hit = (mem_waddr != '0) && ((mem_waddr == rs) || (d_rtread && mem_waddr == rt));

`ifdef CTRL_FORWARD_EN
  logic [RADDR_W-1:0] ex_rs, ex_rt;

  function automatic logic [1:0] fwd_sel(input logic [RADDR_W-1:0] src,
                                         input logic m_wr, input logic [RADDR_W-1:0] m_addr,
                                         input logic w_wr, input logic [RADDR_W-1:0] w_addr);
    if (m_wr && m_addr != '0 && m_addr == src)      return 2'b10;
    else if (w_wr && w_addr != '0 && w_addr == src) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign hazard = ex_memtoreg & ex_hit;
  assign fwdA   = fwd_sel(ex_rs, mem_regwr, mem_waddr, wb_RegWr, wb_waddr);
  assign fwdB   = fwd_sel(ex_rt, mem_regwr, mem_waddr, wb_RegWr, wb_waddr);
`else
  // WB writes the regfile before ID reads it, so only EX and MEM producers are hazards.
  assign hazard = (ex_regwr & ex_hit) | (mem_regwr & mem_hit);
  assign fwdA   = 2'b00;
  assign fwdB   = 2'b00;
`endif

  assign br_take   = ex_branch & (zero ^ ex_brne);
  assign br_take_o = br_take;
  assign stall_o   = hazard & ~br_take;
  assign jump_o    = d_jump & ~stall_o & ~br_take & ~rst;
  assign flush_o   = br_take | jump_o;
  assign ExtOp_o   = d_extop & ~rst;
  assign illegal_o = d_illegal & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_regwr    <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwr    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_brne     <= 1'b0;
      ex_ALUsrc   <= 1'b0;
      ex_ALUctr   <= '0;
      ex_waddr    <= '0;
    end else if (stall_o || br_take) begin
      ex_regwr    <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwr    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_brne     <= 1'b0;
      ex_ALUsrc   <= 1'b0;
      ex_ALUctr   <= '0;
      ex_waddr    <= '0;
    end else begin
      ex_regwr    <= d_regwr;
      ex_memtoreg <= d_memtoreg;
      ex_memwr    <= d_memwr;
      ex_branch   <= d_branch;
      ex_brne     <= d_brne;
      ex_ALUsrc   <= d_alusrc;
      ex_ALUctr   <= d_aluctr;
      ex_waddr    <= d_waddr;
    end
  end

`ifdef CTRL_FORWARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs <= '0;
      ex_rt <= '0;
    end else if (stall_o || br_take) begin
      ex_rs <= '0;
      ex_rt <= '0;
    end else begin
      ex_rs <= rs;
      ex_rt <= rt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_regwr    <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_MemWr    <= 1'b0;
      mem_waddr    <= '0;
      wb_RegWr     <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_waddr     <= '0;
    end else begin
      mem_regwr    <= ex_regwr;
      mem_memtoreg <= ex_memtoreg;
      mem_MemWr    <= ex_memwr;
      mem_waddr    <= ex_waddr;
      wb_RegWr     <= mem_regwr;
      wb_MemtoReg  <= mem_memtoreg;
      wb_waddr     <= mem_waddr;
    end
  end

endmodule
